// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control path: opcode and state encodings,
// the control-strobe bundle, and the opcode-to-strobe decode used in EXEC.
package cpu_pkg;

   localparam int OP_W_C = 3;

   typedef enum logic [2:0] {
      OP_LOAD  = 3'd0,
      OP_STORE = 3'd1,
      OP_ADD   = 3'd2,
      OP_SUB   = 3'd3,
      OP_ADDI  = 3'd4,
      OP_SUBI  = 3'd5,
      OP_BNE   = 3'd6,
      OP_BR    = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ST_HALT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2
   } state_e;

   typedef struct packed {
      logic load_ir;
      logic inc_pc;
      logic load_pc;
      logic load_reg;
      logic alu_add;
      logic alu_sub;
      logic we;
      logic imm;
   } strobe_t;

   localparam strobe_t STROBE_NONE  = strobe_t'(8'h00);
   localparam strobe_t STROBE_FETCH = strobe_t'(8'hC0);

   // Datapath strobes for the EXEC cycle of one opcode; only the listed
   // strobes are raised, so the ALU and write-port groups stay one-hot.
   function automatic strobe_t exec_strobes(input op_e op, input logic z_flag);
      strobe_t s;
      s = STROBE_NONE;
      case (op)
         OP_LOAD:  s.load_reg = 1'b1;
         OP_STORE: s.we       = 1'b1;
         OP_ADD:   begin s.alu_add = 1'b1; s.load_reg = 1'b1; end
         OP_SUB:   begin s.alu_sub = 1'b1; s.load_reg = 1'b1; end
         OP_ADDI:  begin s.alu_add = 1'b1; s.imm = 1'b1; s.load_reg = 1'b1; end
         OP_SUBI:  begin s.alu_sub = 1'b1; s.imm = 1'b1; s.load_reg = 1'b1; end
         OP_BNE:   s.load_pc  = ~z_flag;
         OP_BR:    s.load_pc  = 1'b1;
         default:  s = STROBE_NONE;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/sequencer_chk.sv
// Property checker for the sequencer strobes: the ALU operation select and
// the datapath write enables must each be one-hot or idle on every cycle.
module sequencer_chk (
   input logic clock,
   input logic ALU_add,
   input logic ALU_sub,
   input logic WE,
   input logic load_REG,
   input logic load_PC
);

   a_alu_excl: assert property (@(posedge clock) !(ALU_add && ALU_sub));
   a_wr_excl:  assert property (@(posedge clock) $onehot0({WE, load_REG, load_PC}));

endmodule

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous input. With PULSE_OUT set, q is a
// one-cycle pulse on each rising edge of the synchronized level; otherwise q
// is the synchronized level itself.
module sync_edge #(
   parameter bit PULSE_OUT = 1'b1
) (
   input  logic clock,
   input  logic n_reset,
   input  logic d,
   output logic q
);

   logic meta_r;
   logic sync_r;

   // Two-stage metastability filter.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         meta_r <= 1'b0;
         sync_r <= 1'b0;
      end else begin
         meta_r <= d;
         sync_r <= meta_r;
      end
   end

   if (PULSE_OUT) begin : g_pulse
      logic prev_r;

      // Delayed copy of the synchronized level for rising-edge detection.
      always_ff @(posedge clock or negedge n_reset) begin
         if (!n_reset) begin
            prev_r <= 1'b0;
         end else begin
            prev_r <= sync_r;
         end
      end

      assign q = sync_r & ~prev_r;
   end else begin : g_level
      assign q = sync_r;
   end

endmodule

// File: rtl/sequencer.sv
// Instruction sequencer: HALT / FETCH / EXEC control FSM driving datapath
// strobes, with synchronized run/step controls and a retired-instruction
// counter for the display.
module sequencer
   import cpu_pkg::*;
#(
   parameter int WORD_W = 8,
   parameter int OP_W   = 3
) (
   input  logic              clock,
   input  logic              n_reset,
   input  logic [OP_W-1:0]   op,
   input  logic              z_flag,
   input  logic              run,
   input  logic              step,
   output logic              load_IR,
   output logic              INC_PC,
   output logic              load_PC,
   output logic              load_REG,
   output logic              ALU_add,
   output logic              ALU_sub,
   output logic              WE,
   output logic              IMM,
   output logic              halted,
   output logic [WORD_W-1:0] icount
);

   localparam logic [WORD_W-1:0] ONE_C = {{(WORD_W-1){1'b0}}, 1'b1};

   state_e              state_r;
   state_e              next_state_s;
   strobe_t             strobe_s;
   logic                run_s;
   logic                step_p;
   logic                halted_r;
   logic [WORD_W-1:0]   icount_r;
   op_e                 op_s;

   assign op_s = op_e'(op[OP_W_C-1:0]);

   sync_edge #(.PULSE_OUT(1'b0)) u_run_sync (
      .clock   (clock),
      .n_reset (n_reset),
      .d       (run),
      .q       (run_s)
   );

   sync_edge #(.PULSE_OUT(1'b1)) u_step_sync (
      .clock   (clock),
      .n_reset (n_reset),
      .d       (step),
      .q       (step_p)
   );

   // State register.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         state_r <= ST_HALT;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic; a step pulse outside HALT is simply ignored.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_HALT: begin
            if (run_s || step_p) begin
               next_state_s = ST_FETCH;
            end else begin
               next_state_s = ST_HALT;
            end
         end
         ST_FETCH: next_state_s = ST_EXEC;
         ST_EXEC: begin
            if (run_s) begin
               next_state_s = ST_FETCH;
            end else begin
               next_state_s = ST_HALT;
            end
         end
         default: next_state_s = ST_HALT;
      endcase
   end

   // Strobe decode from the state register, opcode and zero flag only.
   always_comb begin
      strobe_s = STROBE_NONE;
      case (state_r)
         ST_HALT:  strobe_s = STROBE_NONE;
         ST_FETCH: strobe_s = STROBE_FETCH;
         ST_EXEC:  strobe_s = exec_strobes(op_s, z_flag);
         default:  strobe_s = STROBE_NONE;
      endcase
   end

   // Registered HALT indicator, tracking the state register exactly.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         halted_r <= 1'b1;
      end else begin
         halted_r <= (next_state_s == ST_HALT);
      end
   end

   // Retired-instruction counter, bumped at the end of every EXEC cycle.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         icount_r <= {WORD_W{1'b0}};
      end else if (state_r == ST_EXEC) begin
         icount_r <= icount_r + ONE_C;
      end else begin
         icount_r <= icount_r;
      end
   end

   assign load_IR  = strobe_s.load_ir;
   assign INC_PC   = strobe_s.inc_pc;
   assign load_PC  = strobe_s.load_pc;
   assign load_REG = strobe_s.load_reg;
   assign ALU_add  = strobe_s.alu_add;
   assign ALU_sub  = strobe_s.alu_sub;
   assign WE       = strobe_s.we;
   assign IMM      = strobe_s.imm;
   assign halted   = halted_r;
   assign icount   = icount_r;

endmodule

// File: tb/tb_sequencer.sv
// Self-checking bench for the sequencer: a cycle-level reference model built
// from the instruction rules (delay lines for the synchronizers, a phase
// tracker and an opcode strobe table) is compared against the DUT each cycle.
module tb_sequencer;

   logic       clock = 1'b0;
   logic       n_reset;
   logic [2:0] op;
   logic       z_flag;
   logic       run;
   logic       step;
   logic       load_IR, INC_PC, load_PC, load_REG, ALU_add, ALU_sub, WE, IMM;
   logic       halted;
   logic [7:0] icount;

   always #5 clock = ~clock;

   sequencer #(.WORD_W(8), .OP_W(3)) dut (
      .clock    (clock),
      .n_reset  (n_reset),
      .op       (op),
      .z_flag   (z_flag),
      .run      (run),
      .step     (step),
      .load_IR  (load_IR),
      .INC_PC   (INC_PC),
      .load_PC  (load_PC),
      .load_REG (load_REG),
      .ALU_add  (ALU_add),
      .ALU_sub  (ALU_sub),
      .WE       (WE),
      .IMM      (IMM),
      .halted   (halted),
      .icount   (icount)
   );

   sequencer_chk u_chk (
      .clock    (clock),
      .ALU_add  (ALU_add),
      .ALU_sub  (ALU_sub),
      .WE       (WE),
      .load_REG (load_REG),
      .load_PC  (load_PC)
   );

   int    err_cnt = 0;
   int    chk_cnt = 0;
   string scen    = "init";

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s/%s: got=%0h expected=%0h", scen, tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Strobe vector order: load_IR INC_PC load_PC load_REG ALU_add ALU_sub WE IMM
   localparam int P_IDLE  = 0;
   localparam int P_FETCH = 1;
   localparam int P_EXEC  = 2;

   logic [7:0] ref_tab [8] = '{8'h10, 8'h02, 8'h18, 8'h14, 8'h19, 8'h15, 8'h20, 8'h20};
   int         m_phase;
   logic [7:0] m_count;
   bit         run_hist[$];   // [0] = sampled one edge ago, [1] = two edges ago
   bit         step_hist[$];  // same, three deep

   function automatic void model_reset();
      m_phase   = P_IDLE;
      m_count   = 8'd0;
      run_hist  = '{1'b0, 1'b0};
      step_hist = '{1'b0, 1'b0, 1'b0};
   endfunction

   function automatic void model_edge();
      bit seen_run;
      bit step_pulse;
      if (!n_reset) return;
      seen_run   = run_hist[1];
      step_pulse = step_hist[1] && !step_hist[2];
      case (m_phase)
         P_IDLE:  if (seen_run || step_pulse) m_phase = P_FETCH;
         P_FETCH: m_phase = P_EXEC;
         default: begin
            m_count = m_count + 8'd1;
            m_phase = seen_run ? P_FETCH : P_IDLE;
         end
      endcase
      run_hist.push_front(run);
      void'(run_hist.pop_back());
      step_hist.push_front(step);
      void'(step_hist.pop_back());
   endfunction

   function automatic logic [7:0] exp_strobes();
      if (m_phase == P_FETCH) return 8'hC0;
      if (m_phase == P_EXEC) begin
         if (op == 3'd6 && z_flag) return 8'h00;
         return ref_tab[op];
      end
      return 8'h00;
   endfunction

   // One clock: update the model at the edge, compare at the falling edge.
   task automatic cycle();
      @(posedge clock);
      model_edge();
      @(negedge clock);
      check("strobes", {load_IR, INC_PC, load_PC, load_REG, ALU_add, ALU_sub, WE, IMM},
            exp_strobes());
      check("halted", halted, (m_phase == P_IDLE) ? 1 : 0);
      check("icount", icount, m_count);
   endtask

   initial begin
      logic [7:0] c0;
      bit         found;

      n_reset = 1'b0; run = 1'b1; step = 1'b0; op = 3'd2; z_flag = 1'b0;
      model_reset();

      scen = "reset";
      repeat (3) cycle();
      n_reset = 1'b1;

      scen = "first_fetch";
      repeat (2) cycle();
      check("halted_pre", halted, 1);
      cycle();
      check("load_IR", load_IR, 1);
      check("INC_PC", INC_PC, 1);

      scen = "add_run";
      repeat (8) cycle();
      check("icount4", icount, 8'd4);

      scen = "branch";
      op = 3'd6; z_flag = 1'b1; repeat (4) cycle();
      op = 3'd6; z_flag = 1'b0; repeat (4) cycle();
      op = 3'd7; z_flag = 1'b1; repeat (4) cycle();
      op = 3'd7; z_flag = 1'b0; repeat (4) cycle();

      scen = "halt";
      run = 1'b0;
      repeat (6) cycle();
      check("halted", halted, 1);

      scen = "step5";
      c0 = m_count;
      step = 1'b1; repeat (5) cycle();
      step = 1'b0; repeat (8) cycle();
      check("one_instr", icount, c0 + 8'd1);

      scen = "step20";
      c0 = m_count;
      step = 1'b1; repeat (20) cycle();
      step = 1'b0; repeat (8) cycle();
      check("one_instr", icount, c0 + 8'd1);

      scen = "random";
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(7, 0) == 0) run = ~run;
         if ($urandom_range(3, 0) == 0) step = ~step;
         op     = 3'($urandom_range(7, 0));
         z_flag = 1'($urandom_range(1, 0));
         cycle();
      end

      scen = "wrap";
      run = 1'b1; step = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 1200 && !found; i++) begin
         op     = 3'($urandom_range(7, 0));
         z_flag = 1'($urandom_range(1, 0));
         cycle();
         if (m_count == 8'hFF) found = 1'b1;
      end
      check("reach_ff", found, 1);
      found = 1'b0;
      for (int i = 0; i < 4 && !found; i++) begin
         cycle();
         if (m_count == 8'h00) found = 1'b1;
      end
      check("reach_00", found, 1);
      check("wrapped", icount, 8'h00);

      scen = "drop_run";
      found = 1'b0;
      for (int i = 0; i < 4 && !found; i++) begin
         if (m_phase == P_FETCH) found = 1'b1;
         else cycle();
      end
      check("in_fetch", load_IR, 1);
      run = 1'b0;
      cycle();
      check("exec_issued", halted, 0);
      repeat (6) cycle();
      check("halted_after", halted, 1);

      scen = "areset";
      run = 1'b1; op = 3'd1; z_flag = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         cycle();
         if (m_phase == P_EXEC) found = 1'b1;
      end
      check("reach_exec", found, 1);
      check("we_before", WE, 1);
      #2;
      n_reset = 1'b0;
      model_reset();
      #1;
      check("we_async", WE, 0);
      check("halted_async", halted, 1);
      check("icount_async", icount, 8'h00);
      @(negedge clock);
      repeat (3) cycle();
      n_reset = 1'b1;
      repeat (8) cycle();

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/sequencer.md
SEQUENCER -- requirements
Module: sequencer

Interface
REQ-001 Parameter WORD_W, default 8, data word width.
REQ-002 Parameter OP_W, default 3, opcode width.
REQ-003 clock  input  1  single system clock; all state changes on rising edge.
REQ-004 n_reset  input  1  asynchronous, active-low reset.
REQ-005 op  input  OP_W  opcode field from instruction register.
REQ-006 z_flag  input  1  ALU zero flag.
REQ-007 run  input  1  level; 1 = free-run, 0 = halt after current instruction; asynchronous to clock.
REQ-008 step  input  1  pushbutton; rising edge requests one instruction while halted; asynchronous to clock.
REQ-009 load_IR, INC_PC, load_PC, load_REG, ALU_add, ALU_sub, WE, IMM  output  1 each  datapath control strobes.
REQ-010 halted  output  1  high while in HALT state.
REQ-011 icount  output  WORD_W  retired-instruction counter, for seven-segment display.

Function
REQ-012 States SHALL be HALT, FETCH, EXEC; every instruction takes exactly 2 cycles (FETCH then EXEC).
REQ-013 HALT -> FETCH when run_s=1 or step_p=1; otherwise remain in HALT.
REQ-014 FETCH -> EXEC unconditionally.
REQ-015 EXEC -> FETCH if run_s=1; EXEC -> HALT if run_s=0.
REQ-016 run_s SHALL be run through a 2-flop synchronizer; step_p SHALL be a one-cycle pulse on a rising edge of the 2-flop-synchronized step.
REQ-017 A step_p arriving outside HALT SHALL be discarded, not queued.
REQ-018 Deassertion of run mid-instruction SHALL complete that instruction (EXEC still issued), then enter HALT.
REQ-019 FETCH SHALL assert load_IR and INC_PC for one cycle; all other strobes low.
REQ-020 EXEC strobes by op: 000 LOAD: load_REG. 001 STORE: WE. 010 ADD: ALU_add, load_REG. 011 SUB: ALU_sub, load_REG. 100 ADDI: ALU_add, IMM, load_REG. 101 SUBI: ALU_sub, IMM, load_REG. 110 BNE: load_PC iff z_flag=0. 111 BR: load_PC.
REQ-021 Strobes not listed for a state/op combination SHALL be 0; in HALT all strobes SHALL be 0.
REQ-022 Strobes SHALL be combinational from state register, op and z_flag only; no path from run or step.
REQ-023 At most one of ALU_add/ALU_sub and at most one of WE/load_REG/load_PC SHALL be high in any cycle.
REQ-024 icount SHALL increment by 1 at the end of every EXEC cycle, modulo 2**WORD_W (0xFF wraps to 0x00).
REQ-025 halted SHALL be registered state decode (1 exactly when state=HALT).

Reset
REQ-026 n_reset low SHALL immediately force state=HALT, icount=0, synchronizer and edge-detect flops=0, regardless of clock.
REQ-027 During and after reset: all strobes 0, halted=1; reset asserted mid-EXEC SHALL abort that instruction with no strobe glitch beyond the reset edge.
REQ-028 First FETCH after reset release SHALL occur no earlier than 3 clock edges after run is sampled high (synchronizer latency).

Structure
REQ-029 Shared package cpu_pkg SHALL hold the opcode enum (LOAD..BR, OP_W bits) and the state enum (HALT, FETCH, EXEC); decoder and sequencer both import it.
REQ-030 One sub-module, sync_edge, SHALL implement the 2-flop synchronizer plus rising-edge pulse; instantiated for step, with its level output used for run.
REQ-031 The sequencer SHALL contain no datapath storage besides state, icount and synchronizer flops.

Verification
REQ-032 Reset with run=1, release -> halted=1 until first FETCH; load_IR=1 and INC_PC=1 on 3rd-4th edge; icount=0x00 before first EXEC.
REQ-033 run=1, op=010 for 4 instructions -> alternating FETCH/EXEC, ALU_add=load_REG=1 on each EXEC, icount=0x04 after 8 cycles.
REQ-034 run=0, halted; step pulsed once for 5 cycles -> exactly one FETCH+EXEC, icount +1, return to HALT; step held high 20 cycles -> still only one instruction.
REQ-035 op=110 with z_flag=1 -> load_PC=0 in EXEC; op=110 with z_flag=0 -> load_PC=1; op=111 -> load_PC=1 regardless of z_flag.
REQ-036 Preload icount to 0xFF via 255 instructions, run one more -> icount=0x00; run dropped during FETCH -> EXEC still issued, then halted=1.
REQ-037 n_reset pulsed low mid-EXEC of op=001 -> WE drops asynchronously, state=HALT, icount=0x00; assertion checks REQ-023 throughout all scenarios.
